// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared mode encodings, reset pattern and thermometer helper for led_sequencer
package led_seq_pkg;
  localparam logic [1:0] MODE_ROTATE = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;
  localparam logic [31:0] LED_RESET  = 32'd1;
  function automatic logic [31:0] thermo(input logic [5:0] n);
    return (n >= 6'd32) ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
  endfunction
endpackage

// File: rtl/led_seq_prescaler.sv
// led_seq_prescaler: divide-by-DIV step timer; tc is high for one enabled cycle every DIV enabled cycles
//   clk, rst (async, active high), en (count enable, holds count when low),
//   clr (restart the count from zero), tc (terminal count, combinational)
module led_seq_prescaler #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tc = en && (cnt_q == W'(DIV - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr || tc) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: ROTATE / BOUNCE / FILL / HOLD LED pattern generator with registered outputs
//   clk, rst (async, active high), en (step enable), dir (1 = towards higher index),
//   mode (00 ROTATE, 01 BOUNCE, 10 FILL, 11 HOLD), led (pattern), step (advance pulse)
//   LED_SEQ_PRESCALER_EN defined: a step every DIV enabled cycles; undefined: every enabled cycle
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS = 4,
  parameter int DIV    = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led,
  output logic              step
);
  localparam int PW = $clog2(N_LEDS);
  localparam int FW = $clog2(N_LEDS + 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(N_LEDS - 1);
  localparam logic [FW-1:0] FCNT_FULL = FW'(N_LEDS);
  logic [PW-1:0] pos_q, pos_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic bdir_q, bdir_d;
  logic [1:0] mode_q;
  logic [N_LEDS-1:0] led_q, led_d;
  logic step_q;
  logic tc, mode_chg, step_ev;
  assign mode_chg = mode != mode_q;
`ifdef LED_SEQ_PRESCALER_EN
  led_seq_prescaler #(.DIV(DIV)) u_prescaler (
    .clk(clk),
    .rst(rst),
    .en (en),
    .clr(mode_chg),
    .tc (tc)
  );
`else
  assign tc = en && (DIV > 0);
`endif
  // A mode change restarts the sequence and swallows a coincident step.
  assign step_ev = tc && !mode_chg && (mode_q != MODE_HOLD);
  always_comb begin
    pos_d  = pos_q;
    fcnt_d = fcnt_q;
    bdir_d = bdir_q;
    led_d  = led_q;
    if (mode_chg) begin
      pos_d  = '0;
      fcnt_d = '0;
      bdir_d = 1'b1;
      led_d  = (mode == MODE_FILL) ? '0 : (mode == MODE_HOLD) ? led_q : N_LEDS'(LED_RESET);
    end else if (step_ev) begin
      if (mode_q == MODE_FILL)
        fcnt_d = dir ? ((fcnt_q == FCNT_FULL) ? '0 : fcnt_q + 1'b1)
                     : ((fcnt_q == '0) ? FCNT_FULL : fcnt_q - 1'b1);
      else if (mode_q == MODE_BOUNCE) begin
        // Turning at an end moves straight to the neighbour so no end LED is held twice.
        bdir_d = bdir_q ? (pos_q != POS_LAST) : (pos_q == '0);
        pos_d  = bdir_d ? pos_q + 1'b1 : pos_q - 1'b1;
      end else
        pos_d = dir ? ((pos_q == POS_LAST) ? '0 : pos_q + 1'b1)
                    : ((pos_q == '0) ? POS_LAST : pos_q - 1'b1);
      led_d = (mode_q == MODE_FILL) ? N_LEDS'(thermo(6'(fcnt_d))) : N_LEDS'(1) << pos_d;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pos_q  <= '0;
      fcnt_q <= '0;
      bdir_q <= 1'b1;
      mode_q <= MODE_ROTATE;
      led_q  <= N_LEDS'(LED_RESET);
      step_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      fcnt_q <= fcnt_d;
      bdir_q <= bdir_d;
      mode_q <= mode;
      led_q  <= led_d;
      step_q <= step_ev;
    end
  assign led  = led_q;
  assign step = step_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: table-driven, hand-written and randomized checks of led_sequencer against a reference model
module tb_led_sequencer;
  localparam int N = 4;
  localparam int DIV = 3;
`ifdef LED_SEQ_PRESCALER_EN
  localparam int P = DIV;
`else
  localparam int P = 1;
`endif
  logic clk = 1'b0;
  logic rst, en, dir;
  logic [1:0] mode;
  logic [N-1:0] led;
  logic step;
  int checks = 0;
  int failures = 0;
  int m_mode, rp, bk, fc, acc, eled, estep;

  led_sequencer #(.N_LEDS(N), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .dir (dir),
    .mode(mode),
    .led (led),
    .step(step)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         do_rst;
    logic [1:0] mode;
    bit         dir;
    logic [3:0] led;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, logic [1:0] m, bit d, logic [3:0] l);
    vec_t v;
    v.do_rst = r;
    v.mode = m;
    v.dir = d;
    v.led = l;
    tbl.push_back(v);
  endfunction

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0; rp = 0; bk = 0; fc = 0; acc = 0; eled = 1; estep = 0;
  endfunction

  // Predicts the outputs after the coming rising edge from the current inputs.
  function automatic void model_edge();
    bit ev;
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode); rp = 0; bk = 0; fc = 0; acc = 0; estep = 0;
      if (m_mode == 2) eled = 0;
      else if (m_mode != 3) eled = 1;
    end else begin
      ev = en && (acc == P - 1);
      if (en) acc = ev ? 0 : acc + 1;
      estep = (ev && m_mode != 3) ? 1 : 0;
      if (estep == 1) begin
        if (m_mode == 0) begin
          rp = (rp + (dir ? 1 : N - 1)) % N;
          eled = 1 << rp;
        end else if (m_mode == 1) begin
          bk = (bk + 1) % (2 * N - 2);
          eled = 1 << ((bk < N) ? bk : 2 * N - 2 - bk);
        end else begin
          fc = (fc + (dir ? 1 : N)) % (N + 1);
          eled = (1 << fc) - 1;
        end
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("led", int'(led), eled);
    chk("step", int'(step), estep);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_led_async", int'(led), 1);
    chk("rst_step_async", int'(step), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_led_held", int'(led), 1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    int held, nsteps;
    rst = 1'b0; en = 1'b0; dir = 1'b1; mode = 2'b00;
    #1;
    do_reset();

    add(1, 2'b00, 1, 4'b0010); add(0, 2'b00, 1, 4'b0100); add(0, 2'b00, 1, 4'b1000); add(0, 2'b00, 1, 4'b0001);
    add(1, 2'b00, 0, 4'b1000); add(0, 2'b00, 0, 4'b0100); add(0, 2'b00, 0, 4'b0010); add(0, 2'b00, 0, 4'b0001);
    add(0, 2'b00, 0, 4'b1000);
    add(0, 2'b01, 0, 4'b0010); add(0, 2'b01, 1, 4'b0100); add(0, 2'b01, 0, 4'b1000); add(0, 2'b01, 1, 4'b0100);
    add(0, 2'b01, 0, 4'b0010); add(0, 2'b01, 1, 4'b0001); add(0, 2'b01, 0, 4'b0010); add(0, 2'b01, 1, 4'b0100);
    add(0, 2'b10, 1, 4'b0001); add(0, 2'b10, 1, 4'b0011); add(0, 2'b10, 1, 4'b0111); add(0, 2'b10, 1, 4'b1111);
    add(0, 2'b10, 1, 4'b0000); add(0, 2'b10, 1, 4'b0001); add(0, 2'b10, 0, 4'b0000); add(0, 2'b10, 0, 4'b1111);

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      dir = tbl[i].dir;
      en = 1'b1;
      if (tbl[i].do_rst) do_reset();
      got = 0;
      for (int c = 0; c < P + 3; c++) begin
        tick();
        if (step) begin
          got = 1;
          break;
        end
      end
      if (!got) chk("tbl_step_timeout", 0, 1);
      chk("tbl_led", int'(led), int'(tbl[i].led));
    end

    mode = 2'b00; dir = 1'b1; en = 1'b1;
    for (int c = 0; c < P + 3; c++) begin
      tick();
      if (acc == P - 1) break;
    end
    mode = 2'b10;
    tick();
    chk("modechg_step", int'(step), 0);
    chk("modechg_led", int'(led), 0);
    n = 0;
    got = 0;
    for (int c = 0; c < P + 3; c++) begin
      tick();
      n++;
      if (step) begin
        got = 1;
        break;
      end
    end
    chk("fill_first_step_found", int'(got), 1);
    chk("fill_first_step_delay", n, P);
    chk("fill_first_led", int'(led), 1);

    held = int'(led);
    mode = 2'b11;
    nsteps = 0;
    for (int c = 0; c < 2 * P + 3; c++) begin
      tick();
      if (step) nsteps++;
    end
    chk("hold_led", int'(led), held);
    chk("hold_steps", nsteps, 0);

    mode = 2'b00;
    tick();
    en = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("freeze_led", int'(led), 1);
    en = 1'b1;

    mode = 2'b01;
    for (int c = 0; c < 3 * P + 1; c++) tick();
    #2;
    do_reset();
    tick();

    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 3) != 0);
      dir = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
